// File: rtl/bill_sequencer.sv
// Checkout controller: prices items with a shared 4-cycle shift-add multiplier and accumulates a bill total.
// Item latency 5 cycles (item_ready low during MULT/ACC); bill held with bill_valid until bill_ack.
module bill_sequencer #(
    parameter int LIMIT   = 1000,
    parameter int QTY_CAP = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        item_valid,
    input  logic [2:0]  item_id,
    input  logic [3:0]  item_qty,
    output logic        item_ready,
    input  logic        checkout,
    input  logic        bill_ack,
    output logic [12:0] total,
    output logic [12:0] discount,
    output logic [12:0] final_amount,
    output logic        ed,
    output logic        bill_valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_MULT, S_ACC, S_FINAL, S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  bit_cnt;
    logic [2:0]  id_q;
    logic [3:0]  qty_q;
    logic [3:0]  mplier;
    logic [11:0] mcand;
    logic [11:0] prod;
    logic        reject_q;
    logic [3:0]  qty_cnt [8];

    logic        accept;
    logic        id_bad;
    logic        cap_bad;
    logic [4:0]  qty_sum;
    logic        elig;
    logic [12:0] disc_calc;

    function automatic logic [7:0] price(input logic [2:0] id);
        case (id)
            3'd0:    price = 8'd50;
            3'd1:    price = 8'd25;
            3'd2:    price = 8'd100;
            3'd3:    price = 8'd150;
            3'd4:    price = 8'd120;
            default: price = 8'd0;
        endcase
    endfunction

    assign accept    = item_valid & item_ready;
    assign id_bad    = (item_id > 3'd4);
    assign qty_sum   = {1'b0, qty_cnt[item_id]} + {1'b0, item_qty};
    assign cap_bad   = !id_bad && (qty_sum > 5'(QTY_CAP));
    assign elig      = (total >= 13'(LIMIT));
    assign disc_calc = elig ? {2'b00, total[12:2]} : 13'd0;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_COLLECT;
            S_COLLECT: begin
                if (accept)        state_nx = S_MULT;
                else if (checkout) state_nx = S_FINAL;
            end
            S_MULT:    if (bit_cnt == 2'd3) state_nx = S_ACC;
            S_ACC:     state_nx = S_COLLECT;
            S_FINAL:   state_nx = S_DONE;
            S_DONE:    if (bill_ack) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        item_ready = (state == S_COLLECT);
        bill_valid = (state == S_DONE);
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total        <= '0;
            discount     <= '0;
            final_amount <= '0;
            ed           <= 1'b0;
            err          <= 1'b0;
            bit_cnt      <= '0;
            id_q         <= '0;
            qty_q        <= '0;
            mplier       <= '0;
            mcand        <= '0;
            prod         <= '0;
            reject_q     <= 1'b0;
            for (int i = 0; i < 8; i++) qty_cnt[i] <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    total        <= '0;
                    discount     <= '0;
                    final_amount <= '0;
                    ed           <= 1'b0;
                    err          <= 1'b0;
                    for (int i = 0; i < 8; i++) qty_cnt[i] <= '0;
                end
                S_COLLECT: if (accept) begin
                    // Rejected items still run the multiplier, but against a zero price.
                    id_q     <= item_id;
                    qty_q    <= item_qty;
                    mplier   <= item_qty;
                    mcand    <= (id_bad || cap_bad) ? 12'd0 : {4'd0, price(item_id)};
                    reject_q <= id_bad || cap_bad;
                    prod     <= '0;
                    bit_cnt  <= '0;
                    if (id_bad || cap_bad) err <= 1'b1;
                end
                S_MULT: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + 2'd1;
                end
                S_ACC: begin
                    total <= total + {1'b0, prod};
                    if (!reject_q) qty_cnt[id_q] <= qty_cnt[id_q] + qty_q;
                end
                S_FINAL: begin
                    ed           <= elig;
                    discount     <= disc_calc;
                    final_amount <= total - disc_calc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bill_sequencer.sv
// Directed bench for bill_sequencer; expected bills are queued by the stimulus and checked by a monitor.
module tb_bill_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        item_valid = 1'b0;
    logic [2:0]  item_id = '0;
    logic [3:0]  item_qty = '0;
    logic        item_ready;
    logic        checkout = 1'b0;
    logic        bill_ack = 1'b0;
    logic [12:0] total, discount, final_amount;
    logic        ed, bill_valid, busy, err;

    always #5 clk = ~clk;

    bill_sequencer #(.LIMIT(1000), .QTY_CAP(15)) dut (
        .clk(clk), .rst(rst), .start(start), .item_valid(item_valid),
        .item_id(item_id), .item_qty(item_qty), .item_ready(item_ready),
        .checkout(checkout), .bill_ack(bill_ack), .total(total),
        .discount(discount), .final_amount(final_amount), .ed(ed),
        .bill_valid(bill_valid), .busy(busy), .err(err)
    );

    typedef struct {
        int t;
        int d;
        int f;
        int e;
        int r;
    } exp_t;

    exp_t exp_q[$];
    int   total_n = 0;
    int   bad_n = 0;
    logic prev_bv = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total_n++;
        if (act != req) begin
            bad_n++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per bill_valid rising edge.
    always @(negedge clk) begin
        if (bill_valid && !prev_bv) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bill", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bill_total", int'(total), e.t);
                check("bill_discount", int'(discount), e.d);
                check("bill_final", int'(final_amount), e.f);
                check("bill_ed", int'(ed), e.e);
                check("bill_err", int'(err), e.r);
            end
        end
        prev_bv = bill_valid;
    end

    task automatic begin_bill();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", int'(busy), 1);
    endtask

    task automatic send_item(input int id, input int qty, input bit with_co);
        int n;
        int g;
        item_id    = id[2:0];
        item_qty   = qty[3:0];
        item_valid = 1'b1;
        checkout   = with_co;
        n = 0;
        while (!item_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", int'(item_ready), 1);
        @(negedge clk);
        item_valid = 1'b0;
        checkout   = 1'b0;
        g = 0;
        while (!item_ready && g < 20) begin
            g++;
            @(negedge clk);
        end
        check("ready_gap", g, 5);
    endtask

    task automatic close_bill(input int t, input int d, input int f, input int e, input int r);
        exp_t x;
        int   n;
        x.t = t; x.d = d; x.f = f; x.e = e; x.r = r;
        exp_q.push_back(x);
        checkout = 1'b1;
        @(negedge clk);
        checkout = 1'b0;
        n = 0;
        while (!bill_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bill_wait", int'(bill_valid), 1);
    endtask

    task automatic ack_bill();
        bill_ack = 1'b1;
        @(negedge clk);
        bill_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_total", int'(total), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(bill_valid), 0);
        check("rst_ready", int'(item_ready), 0);
        check("rst_err", int'(err), 0);

        // 1: 3x50 + 10x100 = 1150
        begin_bill();
        send_item(0, 3, 0);
        send_item(2, 10, 0);
        close_bill(1150, 287, 863, 1, 0);
        ack_bill();

        // 2: exactly at the limit, then just below it
        begin_bill();
        send_item(2, 10, 0);
        close_bill(1000, 250, 750, 1, 0);
        ack_bill();
        begin_bill();
        send_item(1, 15, 0);
        send_item(0, 12, 0);
        close_bill(975, 0, 975, 0, 0);
        ack_bill();

        // 3: every product at the quantity cap
        begin_bill();
        for (int i = 0; i < 5; i++) send_item(i, 15, 0);
        close_bill(6675, 1668, 5007, 1, 0);
        ack_bill();

        // 4: cap overflow and invalid id
        begin_bill();
        send_item(0, 10, 0);
        send_item(0, 6, 0);
        check("cap_err", int'(err), 1);
        check("cap_total", int'(total), 500);
        send_item(6, 3, 0);
        check("badid_err", int'(err), 1);
        check("badid_total", int'(total), 500);
        close_bill(500, 0, 500, 0, 1);
        ack_bill();

        // 5: checkout coincident with an item is dropped; reset mid-multiply
        begin_bill();
        send_item(0, 3, 1);
        check("co_collect", int'(item_ready), 1);
        check("co_valid", int'(bill_valid), 0);
        check("co_total", int'(total), 150);
        item_id = 3'd2; item_qty = 4'd2; item_valid = 1'b1;
        @(negedge clk);
        item_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_total", int'(total), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_valid", int'(bill_valid), 0);
        check("mrst_ready", int'(item_ready), 0);
        check("mrst_final", int'(final_amount), 0);

        // 6: hold the bill, then ack and restart
        begin_bill();
        send_item(3, 7, 0);
        close_bill(1050, 262, 788, 1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", int'(bill_valid), 1);
            check("hold_final", int'(final_amount), 788);
        end
        ack_bill();
        check("ack_valid", int'(bill_valid), 0);
        check("ack_busy", int'(busy), 0);
        check("ack_total", int'(total), 1050);
        begin_bill();
        check("restart_total", int'(total), 0);
        check("restart_final", int'(final_amount), 0);

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
